// File: rtl/sincos_arbiter_if.sv
// sincos_arbiter_if
//
// Bundles the requester-side handshake, the shared sin/cos LUT connection
// and the response bus of sincos_arbiter into one interface.
//
// Signals:
//   req        requester -> arbiter  level request per requester
//   phase      requester -> arbiter  packed 10-bit phase per requester, [10*i+9:10*i]
//   gnt        arbiter -> requester  one-hot, single-cycle grant pulse
//   lut_phase  arbiter -> LUT        registered phase for the shared sin_cos ROM
//   lut_sin    LUT -> arbiter        signed sine returned by the ROM
//   lut_cos    LUT -> arbiter        signed cosine returned by the ROM
//   rsp_valid  arbiter -> requester  one-hot, single-cycle response strobe
//   rsp_sin    arbiter -> requester  registered sine, shared by all requesters
//   rsp_cos    arbiter -> requester  registered cosine, shared by all requesters
//
// Modports:
//   slave   the arbiter itself
//   master  everything around it (requesters plus the LUT)

interface sincos_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic        [NUM_REQ-1:0]    req;
    logic        [NUM_REQ*10-1:0] phase;
    logic        [NUM_REQ-1:0]    gnt;
    logic        [9:0]            lut_phase;
    logic signed [17:0]           lut_sin;
    logic signed [17:0]           lut_cos;
    logic        [NUM_REQ-1:0]    rsp_valid;
    logic signed [17:0]           rsp_sin;
    logic signed [17:0]           rsp_cos;

    modport slave (
        input  req,
        input  phase,
        input  lut_sin,
        input  lut_cos,
        output gnt,
        output lut_phase,
        output rsp_valid,
        output rsp_sin,
        output rsp_cos
    );

    modport master (
        output req,
        output phase,
        output lut_sin,
        output lut_cos,
        input  gnt,
        input  lut_phase,
        input  rsp_valid,
        input  rsp_sin,
        input  rsp_cos
    );
endinterface

// File: rtl/sincos_arbiter.sv
// sincos_arbiter
//
// Round-robin arbiter sharing one sin_cos lookup ROM between NUM_REQ
// requesters (ship, bullets, asteroids). Each cycle at most one requester
// is granted; its phase is registered onto lut_phase, and a tag pipeline
// whose depth matches the ROM latency carries the winner's id so the ROM
// output can be returned to the right requester with a one-hot strobe.
//
// Parameters:
//   NUM_REQ      number of requesters, 2..8
//   LUT_LATENCY  clock edges from lut_phase change to matching ROM output, 1..4
//
// Ports:
//   clk     rising-edge clock
//   resetN  asynchronous active-low reset; clears every output, the round-robin
//           pointer and all in-flight tags
//   bus     sincos_arbiter_if slave modport (req/phase in, gnt/lut_phase out,
//           lut_sin/lut_cos in, rsp_valid/rsp_sin/rsp_cos out)
//
// Timing: req in C0 -> gnt and lut_phase in C1 -> ROM data in C1+LUT_LATENCY
//         -> rsp_valid/rsp_sin/rsp_cos in C2+LUT_LATENCY.

module sincos_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LUT_LATENCY = 1
) (
    input  logic             clk,
    input  logic             resetN,
    sincos_arbiter_if.slave  bus
);

    localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam int                 LAST_STG = LUT_LATENCY - 1;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (id == IDX_W'(i));
        end
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                id = IDX_W'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [9:0] phase_of(input logic [NUM_REQ*10-1:0] ph,
                                            input logic [IDX_W-1:0]      id);
        logic [9:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id == IDX_W'(i)) begin
                sel = ph[10*i +: 10];
            end
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic        [NUM_REQ-1:0] gnt_p0;
    logic        [9:0]         lut_phase_p0;
    logic        [IDX_W-1:0]   ptr;

    logic        [LUT_LATENCY-1:0] vld_p;
    logic        [IDX_W-1:0]       id_p [LUT_LATENCY];

    logic        [NUM_REQ-1:0] rsp_valid_p2;
    logic signed [17:0]        rsp_sin_p2;
    logic signed [17:0]        rsp_cos_p2;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;

    // The requester granted this cycle is masked out so it cannot be granted
    // again at the next edge while it is still dropping req. The walk wraps
    // explicitly at NUM_REQ-1, so non-power-of-two counts work.
    always_comb begin
        eligible = bus.req & ~gnt_p0;
        found    = 1'b0;
        win      = '0;
        cand     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    // ---- stage p0: grant, LUT phase and pointer update ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gnt_p0       <= '0;
            lut_phase_p0 <= '0;
            ptr          <= '0;
        end else if (found) begin
            gnt_p0       <= idx_to_onehot(win);
            lut_phase_p0 <= phase_of(bus.phase, win);
            ptr          <= (win == LAST_IDX) ? '0 : win + 1'b1;
        end else begin
            gnt_p0       <= '0;
        end
    end

    // ---- stage p1: tag pipeline, depth LUT_LATENCY ----
    // Valid bits are cleared by reset so in-flight lookups are discarded.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= |gnt_p0;
            for (int s = 1; s < LUT_LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // The id only matters while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        id_p[0] <= onehot_to_idx(gnt_p0);
        for (int s = 1; s < LUT_LATENCY; s++) begin
            id_p[s] <= id_p[s-1];
        end
    end

    // ---- stage p2: response registers ----
    // rsp_sin/rsp_cos hold between responses; the strobe lasts one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rsp_valid_p2 <= '0;
            rsp_sin_p2   <= '0;
            rsp_cos_p2   <= '0;
        end else begin
            rsp_valid_p2 <= vld_p[LAST_STG] ? idx_to_onehot(id_p[LAST_STG]) : '0;
            if (vld_p[LAST_STG]) begin
                rsp_sin_p2 <= bus.lut_sin;
                rsp_cos_p2 <= bus.lut_cos;
            end
        end
    end

    assign bus.gnt       = gnt_p0;
    assign bus.lut_phase = lut_phase_p0;
    assign bus.rsp_valid = rsp_valid_p2;
    assign bus.rsp_sin   = rsp_sin_p2;
    assign bus.rsp_cos   = rsp_cos_p2;

endmodule

// File: tb/tb_sincos_arbiter.sv
// tb_sincos_arbiter
//
// Drives two arbiters in parallel from the same requester stimulus: one with
// LUT_LATENCY=1, one with LUT_LATENCY=3, each with its own LUT model that
// returns sin=phase, cos=-phase after the configured latency. Stimulus pushes
// hand-computed expected grants and responses (id, phase, cycle) into queues;
// a monitor on the falling edge pops and compares whenever a DUT presents a
// grant or a response.

module tb_sincos_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    sincos_arbiter_if #(.NUM_REQ(N)) ifa ();
    sincos_arbiter_if #(.NUM_REQ(N)) ifb ();

    sincos_arbiter #(.NUM_REQ(N), .LUT_LATENCY(1)) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifa)
    );

    sincos_arbiter #(.NUM_REQ(N), .LUT_LATENCY(3)) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifb)
    );

    // Requester stimulus shared by both DUTs
    logic [N-1:0] req;
    logic [9:0]   ph_arr [N];
    logic [N*10-1:0] phase;

    assign phase     = {ph_arr[3], ph_arr[2], ph_arr[1], ph_arr[0]};
    assign ifa.req   = req;
    assign ifb.req   = req;
    assign ifa.phase = phase;
    assign ifb.phase = phase;

    // LUT models: latency 1 and latency 3
    logic [9:0] lut_a;
    logic [9:0] lut_b [3];

    always @(posedge clk) begin
        lut_a    <= ifa.lut_phase;
        lut_b[0] <= ifb.lut_phase;
        lut_b[1] <= lut_b[0];
        lut_b[2] <= lut_b[1];
    end

    assign ifa.lut_sin = $signed({8'd0, lut_a});
    assign ifa.lut_cos = -$signed({8'd0, lut_a});
    assign ifb.lut_sin = $signed({8'd0, lut_b[2]});
    assign ifb.lut_cos = -$signed({8'd0, lut_b[2]});

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        int id;
        int ph;
        int cyc;
    } exp_t;

    exp_t gq_a[$];
    exp_t gq_b[$];
    exp_t rq_a[$];
    exp_t rq_b[$];

    int n_pass  = 0;
    int n_total = 0;
    int gcnt [2][N];
    int rcnt [2][N];
    logic [N-1:0] prev_gnt [2];

    int chk_seq  = 0;
    int done_seq = 0;
    int exp_cnt [N];

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] one;
        one = 1;
        return one << id;
    endfunction

    task automatic chk(input int d, input bit ok, input string name,
                       input longint act, input longint want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL L%0d %s cycle=%0d got=%0d required=%0d",
                      (d == 0) ? 1 : 3, name, cyc, act, want);
    endtask

    task automatic mon(input int d, input logic [N-1:0] g, input logic [9:0] lp,
                       input logic [N-1:0] rv, input logic signed [17:0] rs,
                       input logic signed [17:0] rc);
        exp_t e;
        bit   empty;
        if (resetN === 1'b0) begin
            chk(d, {g, lp, rv, rs, rc} === '0, "reset_outputs",
                longint'({g, lp, rv, rs, rc}), 0);
            for (int i = 0; i < N; i++) begin
                gcnt[d][i] = 0;
                rcnt[d][i] = 0;
            end
            prev_gnt[d] = '0;
            return;
        end
        if (g !== '0) begin
            chk(d, (g & prev_gnt[d]) == '0, "no_double_grant", longint'(g), 0);
            empty = (d == 0) ? (gq_a.size() == 0) : (gq_b.size() == 0);
            if (empty) begin
                chk(d, 1'b0, "unexpected_grant", longint'(g), 0);
            end else begin
                if (d == 0) e = gq_a.pop_front();
                else        e = gq_b.pop_front();
                chk(d, g == onehot(e.id), "gnt", longint'(g), longint'(onehot(e.id)));
                chk(d, lp == 10'(e.ph), "lut_phase", longint'(lp), e.ph);
                chk(d, cyc == e.cyc, "gnt_cycle", cyc, e.cyc);
                gcnt[d][e.id]++;
            end
        end
        prev_gnt[d] = g;
        if (rv !== '0) begin
            empty = (d == 0) ? (rq_a.size() == 0) : (rq_b.size() == 0);
            if (empty) begin
                chk(d, 1'b0, "unexpected_rsp", longint'(rv), 0);
            end else begin
                if (d == 0) e = rq_a.pop_front();
                else        e = rq_b.pop_front();
                chk(d, rv == onehot(e.id), "rsp_valid", longint'(rv), longint'(onehot(e.id)));
                chk(d, longint'(rs) == e.ph, "rsp_sin", rs, e.ph);
                chk(d, longint'(rc) == -e.ph, "rsp_cos", rc, -e.ph);
                chk(d, cyc == e.cyc, "rsp_cycle", cyc, e.cyc);
                rcnt[d][e.id]++;
            end
        end
    endtask

    // Monitor: compares on every falling edge, and runs count checks on request
    always @(negedge clk) begin
        mon(0, ifa.gnt, ifa.lut_phase, ifa.rsp_valid, ifa.rsp_sin, ifa.rsp_cos);
        mon(1, ifb.gnt, ifb.lut_phase, ifb.rsp_valid, ifb.rsp_sin, ifb.rsp_cos);
        if (chk_seq != done_seq) begin
            done_seq = chk_seq;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    chk(d, gcnt[d][i] == exp_cnt[i], "grant_count", gcnt[d][i], exp_cnt[i]);
                    chk(d, rcnt[d][i] == exp_cnt[i], "rsp_count", rcnt[d][i], exp_cnt[i]);
                end
            end
            chk(0, gq_a.size() == 0, "pending_grants", gq_a.size(), 0);
            chk(0, rq_a.size() == 0, "pending_rsps", rq_a.size(), 0);
            chk(1, gq_b.size() == 0, "pending_grants", gq_b.size(), 0);
            chk(1, rq_b.size() == 0, "pending_rsps", rq_b.size(), 0);
        end
    end

    // Stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
    endtask

    // Response arrives LUT_LATENCY+1 cycles after the grant cycle.
    task automatic expect_txn(input int id, input int ph, input int gcyc);
        exp_t e;
        e.id  = id;
        e.ph  = ph;
        e.cyc = gcyc;
        gq_a.push_back(e);
        gq_b.push_back(e);
        e.cyc = gcyc + 2;
        rq_a.push_back(e);
        e.cyc = gcyc + 4;
        rq_b.push_back(e);
    endtask

    task automatic expect_gnt_only(input int id, input int ph, input int gcyc);
        exp_t e;
        e.id  = id;
        e.ph  = ph;
        e.cyc = gcyc;
        gq_a.push_back(e);
        gq_b.push_back(e);
    endtask

    task automatic count_check(input int c0, input int c1, input int c2, input int c3);
        exp_cnt[0] = c0;
        exp_cnt[1] = c1;
        exp_cnt[2] = c2;
        exp_cnt[3] = c3;
        chk_seq++;
        step();
    endtask

    // Each requester drops req the cycle after it sees its grant.
    task automatic run_release(input int n);
        logic [N-1:0] g;
        g = ifa.gnt;
        for (int t = 0; t < n; t++) begin
            step();
            req = req & ~g;
            g   = ifa.gnt;
        end
    endtask

    initial begin
        int c0;
        logic [N-1:0] g;
        req = '0;
        for (int i = 0; i < N; i++) ph_arr[i] = '0;
        resetN = 1'b1;
        #1 resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;

        // Single request: req[2], phase 0x155 -> gnt C1, rsp C3 (L1) / C5 (L3)
        do_reset();
        c0 = cyc;
        ph_arr[2] = 10'h155;
        req = 4'b0100;
        expect_txn(2, 341, c0 + 1);
        run_release(10);
        count_check(0, 0, 1, 0);

        // Simultaneous: req 1010, phases 1 and 3 -> gnt 0010 then 1000
        do_reset();
        c0 = cyc;
        ph_arr[1] = 10'd1;
        ph_arr[3] = 10'd3;
        req = 4'b1010;
        expect_txn(1, 1, c0 + 1);
        expect_txn(3, 3, c0 + 2);
        run_release(10);
        count_check(0, 1, 0, 1);

        // Fairness: all four requesting, each back one cycle after dropping
        do_reset();
        c0 = cyc;
        for (int i = 0; i < N; i++) ph_arr[i] = 10'(100 + 37 * i);
        for (int k = 0; k < 40; k++) expect_txn(k % 4, 100 + 37 * (k % 4), c0 + 1 + k);
        req = 4'hf;
        g   = '0;
        for (int t = 1; t < 40; t++) begin
            step();
            req = 4'hf & ~g;
            g   = ifa.gnt;
        end
        step();
        req = '0;
        repeat (8) step();
        count_check(10, 10, 10, 10);

        // No double grant: req[0] held for 10 cycles -> grants C1,C3,C5,C7,C9
        do_reset();
        c0 = cyc;
        ph_arr[0] = 10'h2AA;
        req = 4'b0001;
        for (int k = 0; k < 5; k++) expect_txn(0, 682, c0 + 1 + 2 * k);
        repeat (10) step();
        req = '0;
        repeat (8) step();
        count_check(5, 0, 0, 0);

        // Reset mid-flight: grant req[1] in C1, reset during C2, re-grant in C4
        do_reset();
        c0 = cyc;
        ph_arr[1] = 10'h3C7;
        req = 4'b0010;
        expect_gnt_only(1, 967, c0 + 1);
        step();
        step();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        expect_txn(1, 967, c0 + 4);
        step();
        step();
        req = '0;
        repeat (8) step();
        count_check(0, 1, 0, 0);

        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
